code_lock_seq: RTL and testbench
================================

CODE_LOCK_SEQ -- requirements
Module: code_lock_seq

Interface
REQ-001 SHALL have parameter CODE_LEN, 4, number of key digits per code (2..16).
REQ-002 SHALL have parameter KEY_W, 3, width of one key digit.
REQ-003 SHALL have parameter DEFAULT_CODE, {3'd3,3'd2,3'd1,3'd1}, reset code; digit i = bits [i*KEY_W +: KEY_W]; digit 0 entered first.
REQ-004 SHALL have parameter MAX_TRIES, 3, consecutive failed entries before lockout.
REQ-005 SHALL have parameter LOCKOUT_CYC, 1000, lockout duration in clk cycles.
REQ-006 SHALL have parameter UNLOCK_CYC, 500, idle cycles in UNLOCKED before auto-relock.
REQ-007 SHALL have parameter ENTRY_TO, 200, idle cycles in ENTRY before the partial entry is aborted.
REQ-008 SHALL have port clk, input, 1, clock; all state changes on its rising edge.
REQ-009 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-010 SHALL have port key_valid, input, 1, one key digit presented this cycle.
REQ-011 SHALL have port key_val, input, KEY_W, key digit value; sampled only when key_valid=1.
REQ-012 SHALL have port prog_en, input, 1, level; enables code programming while unlocked.
REQ-013 SHALL have port relock, input, 1, request immediate relock.
REQ-014 SHALL have port unlock, output, 1, registered; high in UNLOCKED and PROGRAM.
REQ-015 SHALL have port lockout, output, 1, registered; high in LOCKOUT.
REQ-016 SHALL have port fail_pulse, output, 1, one-cycle pulse per failed complete entry.
REQ-017 SHALL have port prog_done, output, 1, one-cycle pulse when a new code is committed.
REQ-018 SHALL have port tries_left, output, $clog2(MAX_TRIES+1), MAX_TRIES minus the current consecutive fail count.

Function
REQ-019 SHALL implement the states IDLE, ENTRY, UNLOCKED, PROGRAM and LOCKOUT.
REQ-020 In IDLE, a key SHALL compare against digit 0, set idx=1 and enter ENTRY; any mismatch SHALL set a sticky mismatch flag.
REQ-021 In ENTRY, each key SHALL compare against digit idx and increment idx; no early reject, all CODE_LEN digits are always consumed.
REQ-022 On the CODE_LEN-th key with no mismatch, the FSM SHALL enter UNLOCKED, assert unlock the next cycle, clear the fail count and restore tries_left=MAX_TRIES.
REQ-023 On the CODE_LEN-th key with a mismatch, the FSM SHALL pulse fail_pulse the next cycle and increment the fail count.
REQ-024 After a failed entry, if the fail count < MAX_TRIES the FSM SHALL return to IDLE; otherwise it SHALL enter LOCKOUT.
REQ-025 LOCKOUT SHALL hold lockout=1 for exactly LOCKOUT_CYC cycles and ignore all keys; on exit it SHALL clear the fail count and enter IDLE.
REQ-026 In ENTRY, ENTRY_TO consecutive cycles without key_valid SHALL return the FSM to IDLE, clear idx and mismatch, and not count a failure.
REQ-027 In UNLOCKED, relock=1 or UNLOCK_CYC cycles without key_valid SHALL return the FSM to IDLE with unlock=0 the next cycle.
REQ-028 In UNLOCKED, keys with prog_en=0 SHALL be ignored but SHALL restart the idle timer.
REQ-029 In UNLOCKED, a key with prog_en=1 SHALL be captured as new digit 0 and the FSM SHALL enter PROGRAM.
REQ-030 In PROGRAM, keys SHALL fill a shadow code buffer; on the CODE_LEN-th digit the FSM SHALL copy the buffer to the code register atomically, pulse prog_done, return to UNLOCKED and restart the idle timer.
REQ-031 In PROGRAM, prog_en falling before completion SHALL abort programming, leave the code unchanged and return to UNLOCKED.
REQ-032 When relock and key_valid occur in the same cycle, relock SHALL win and the key SHALL be ignored; relock in PROGRAM SHALL abort programming and enter IDLE.
REQ-033 The relock input SHALL have no effect in IDLE, ENTRY or LOCKOUT.

Reset
REQ-034 Asserting rst at any time, including mid-entry, mid-program or in lockout, SHALL force IDLE and load code=DEFAULT_CODE.
REQ-035 Reset SHALL set idx=0, clear mismatch, clear the fail count, clear all timers, set unlock=lockout=fail_pulse=prog_done=0 and set tries_left=MAX_TRIES.

Verification (CODE_LEN=4, KEY_W=3, MAX_TRIES=3, LOCKOUT_CYC=16, UNLOCK_CYC=32, ENTRY_TO=20, code 1,1,2,3)
REQ-036 Keys 1,1,2,3 -> unlock=1 the cycle after the 4th key, tries_left=3; 32 idle cycles -> unlock=0.
REQ-037 Keys 1,1,2,4 -> fail_pulse once and tries_left=2; three bad entries -> lockout=1 for exactly 16 cycles, keys ignored, then tries_left=3.
REQ-038 Keys 1,1 then 20 idle cycles -> IDLE with no fail_pulse; then keys 1,1,2,3 -> unlock.
REQ-039 Unlock, then keys 5,6,7,0 with prog_en=1 -> prog_done pulse; relock; keys 1,1,2,3 -> fail; keys 5,6,7,0 -> unlock.
REQ-040 Program aborted after 2 digits by prog_en=0 -> old code still opens; relock with key_valid in the same cycle -> IDLE; rst mid-entry -> all outputs 0 and DEFAULT_CODE restored.

Source files
------------

// File: rtl/code_lock_seq.sv
// Digit-code lock: sequential key entry with try counting, timed lockout,
// idle auto-relock and in-place reprogramming of the code while unlocked.
module code_lock_seq #(
  parameter int CODE_LEN = 4,
  parameter int KEY_W = 3,
  parameter logic [CODE_LEN*KEY_W-1:0] DEFAULT_CODE = {3'd3, 3'd2, 3'd1, 3'd1},
  parameter int MAX_TRIES = 3,
  parameter int LOCKOUT_CYC = 1000,
  parameter int UNLOCK_CYC = 500,
  parameter int ENTRY_TO = 200
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             key_valid,
  input  logic [KEY_W-1:0]                 key_val,
  input  logic                             prog_en,
  input  logic                             relock,
  output logic                             unlock,
  output logic                             lockout,
  output logic                             fail_pulse,
  output logic                             prog_done,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left
);

  localparam int CNT_W = $clog2(MAX_TRIES + 1);
  localparam int IDX_W = $clog2(CODE_LEN);
  localparam int MAX_A = (LOCKOUT_CYC > UNLOCK_CYC) ? LOCKOUT_CYC : UNLOCK_CYC;
  localparam int MAX_CYC = (MAX_A > ENTRY_TO) ? MAX_A : ENTRY_TO;
  localparam int TMR_W = $clog2(MAX_CYC + 1);

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(CODE_LEN - 1);
  localparam logic [TMR_W-1:0] LOCK_LAST   = TMR_W'(LOCKOUT_CYC - 1);
  localparam logic [TMR_W-1:0] UNLOCK_LAST = TMR_W'(UNLOCK_CYC - 1);
  localparam logic [TMR_W-1:0] ENTRY_LAST  = TMR_W'(ENTRY_TO - 1);
  localparam logic [CNT_W-1:0] TRIES_MAX   = CNT_W'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_UNLOCKED,
    S_PROGRAM,
    S_LOCKOUT
  } state_t;

  state_t                             state_q, state_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic                               mismatch_q, mismatch_d;
  logic [CNT_W-1:0]                   fail_cnt_q, fail_cnt_d;
  logic [TMR_W-1:0]                   timer_q, timer_d;
  logic [CODE_LEN-1:0][KEY_W-1:0]     code_q, code_d;
  logic [CODE_LEN-1:0][KEY_W-1:0]     shadow_q, shadow_d;
  logic                               unlock_q, unlock_d;
  logic                               lockout_q, lockout_d;
  logic                               fail_pulse_q, fail_pulse_d;
  logic                               prog_done_q, prog_done_d;
  logic [CNT_W-1:0]                   tries_left_q, tries_left_d;

  logic                               key_hit;
  logic [CNT_W-1:0]                   fail_inc;

  assign key_hit  = (key_val == code_q[idx_q]);
  assign fail_inc = fail_cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    mismatch_d   = mismatch_q;
    fail_cnt_d   = fail_cnt_q;
    timer_d      = timer_q;
    code_d       = code_q;
    shadow_d     = shadow_q;
    fail_pulse_d = 1'b0;
    prog_done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (key_valid) begin
          mismatch_d = !key_hit;
          idx_d      = IDX_W'(1);
          timer_d    = '0;
          state_d    = S_ENTRY;
        end
      end

      // Every digit is consumed even after a mismatch so timing leaks nothing.
      S_ENTRY: begin
        if (key_valid) begin
          timer_d = '0;
          if (idx_q == LAST_IDX) begin
            idx_d      = '0;
            mismatch_d = 1'b0;
            if (mismatch_q || !key_hit) begin
              fail_pulse_d = 1'b1;
              fail_cnt_d   = fail_inc;
              state_d      = (fail_inc >= TRIES_MAX) ? S_LOCKOUT : S_IDLE;
            end else begin
              fail_cnt_d = '0;
              state_d    = S_UNLOCKED;
            end
          end else begin
            idx_d      = idx_q + 1'b1;
            mismatch_d = mismatch_q | !key_hit;
          end
        end else if (timer_q == ENTRY_LAST) begin
          state_d    = S_IDLE;
          idx_d      = '0;
          mismatch_d = 1'b0;
          timer_d    = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_UNLOCKED: begin
        if (relock) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else if (key_valid) begin
          timer_d = '0;
          if (prog_en) begin
            shadow_d[0] = key_val;
            idx_d       = IDX_W'(1);
            state_d     = S_PROGRAM;
          end
        end else if (timer_q == UNLOCK_LAST) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_PROGRAM: begin
        if (relock) begin
          state_d = S_IDLE;
          idx_d   = '0;
          timer_d = '0;
        end else if (!prog_en) begin
          state_d = S_UNLOCKED;
          idx_d   = '0;
          timer_d = '0;
        end else if (key_valid) begin
          if (idx_q == LAST_IDX) begin
            code_d        = shadow_q;
            code_d[idx_q] = key_val;
            prog_done_d   = 1'b1;
            state_d       = S_UNLOCKED;
            idx_d         = '0;
            timer_d       = '0;
          end else begin
            shadow_d[idx_q] = key_val;
            idx_d           = idx_q + 1'b1;
          end
        end
      end

      S_LOCKOUT: begin
        if (timer_q == LOCK_LAST) begin
          state_d    = S_IDLE;
          fail_cnt_d = '0;
          timer_d    = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        timer_d = '0;
      end
    endcase

    unlock_d     = (state_d == S_UNLOCKED) || (state_d == S_PROGRAM);
    lockout_d    = (state_d == S_LOCKOUT);
    tries_left_d = TRIES_MAX - fail_cnt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      mismatch_q   <= 1'b0;
      fail_cnt_q   <= '0;
      timer_q      <= '0;
      code_q       <= DEFAULT_CODE;
      shadow_q     <= '0;
      unlock_q     <= 1'b0;
      lockout_q    <= 1'b0;
      fail_pulse_q <= 1'b0;
      prog_done_q  <= 1'b0;
      tries_left_q <= TRIES_MAX;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      mismatch_q   <= mismatch_d;
      fail_cnt_q   <= fail_cnt_d;
      timer_q      <= timer_d;
      code_q       <= code_d;
      shadow_q     <= shadow_d;
      unlock_q     <= unlock_d;
      lockout_q    <= lockout_d;
      fail_pulse_q <= fail_pulse_d;
      prog_done_q  <= prog_done_d;
      tries_left_q <= tries_left_d;
    end
  end

  assign unlock     = unlock_q;
  assign lockout    = lockout_q;
  assign fail_pulse = fail_pulse_q;
  assign prog_done  = prog_done_q;
  assign tries_left = tries_left_q;

endmodule

// File: tb/tb_code_lock_seq.sv
// Bench for code_lock_seq: fixed vector table, directed corner sequences and
// a random run, all compared against a sequence-level behavioural model.
module tb_code_lock_seq;

  localparam int CODE_LEN = 4;
  localparam int KEY_W = 3;
  localparam int MAX_TRIES = 3;
  localparam int LOCKOUT_CYC = 16;
  localparam int UNLOCK_CYC = 32;
  localparam int ENTRY_TO = 20;

  localparam int M_IDLE = 0;
  localparam int M_ENTRY = 1;
  localparam int M_UNL = 2;
  localparam int M_PROG = 3;
  localparam int M_LOCK = 4;

  logic             clk;
  logic             rst;
  logic             key_valid;
  logic [KEY_W-1:0] key_val;
  logic             prog_en;
  logic             relock;
  logic             unlock;
  logic             lockout;
  logic             fail_pulse;
  logic             prog_done;
  logic [1:0]       tries_left;

  int vec_cnt = 0;
  int err_cnt = 0;

  code_lock_seq #(
    .CODE_LEN(CODE_LEN),
    .KEY_W(KEY_W),
    .DEFAULT_CODE({3'd3, 3'd2, 3'd1, 3'd1}),
    .MAX_TRIES(MAX_TRIES),
    .LOCKOUT_CYC(LOCKOUT_CYC),
    .UNLOCK_CYC(UNLOCK_CYC),
    .ENTRY_TO(ENTRY_TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_valid(key_valid),
    .key_val(key_val),
    .prog_en(prog_en),
    .relock(relock),
    .unlock(unlock),
    .lockout(lockout),
    .fail_pulse(fail_pulse),
    .prog_done(prog_done),
    .tries_left(tries_left)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: remembers whole digit sequences and counts elapsed cycles.
  int m_mode;
  int m_code[CODE_LEN];
  int m_entry[$];
  int m_newc[$];
  int m_fails;
  int m_idle;
  int m_lock_left;
  bit m_fail;
  bit m_done;

  task automatic model_reset();
    m_mode = M_IDLE;
    m_code[0] = 1; m_code[1] = 1; m_code[2] = 2; m_code[3] = 3;
    m_entry.delete();
    m_newc.delete();
    m_fails = 0;
    m_idle = 0;
    m_lock_left = 0;
    m_fail = 0;
    m_done = 0;
  endtask

  task automatic model_step(input bit kv, input int kval, input bit pe, input bit rl);
    bit ok;
    m_fail = 0;
    m_done = 0;
    case (m_mode)
      M_IDLE: if (kv) begin
        m_entry.delete();
        m_entry.push_back(kval);
        m_idle = 0;
        m_mode = M_ENTRY;
      end
      M_ENTRY: begin
        if (kv) begin
          m_entry.push_back(kval);
          m_idle = 0;
          if (m_entry.size() == CODE_LEN) begin
            ok = 1;
            foreach (m_entry[i]) if (m_entry[i] != m_code[i]) ok = 0;
            m_entry.delete();
            if (ok) begin
              m_fails = 0;
              m_mode = M_UNL;
            end else begin
              m_fails++;
              m_fail = 1;
              if (m_fails >= MAX_TRIES) begin
                m_mode = M_LOCK;
                m_lock_left = LOCKOUT_CYC;
              end else begin
                m_mode = M_IDLE;
              end
            end
          end
        end else begin
          m_idle++;
          if (m_idle >= ENTRY_TO) begin
            m_mode = M_IDLE;
            m_entry.delete();
            m_idle = 0;
          end
        end
      end
      M_UNL: begin
        if (rl) begin
          m_mode = M_IDLE;
        end else if (kv) begin
          m_idle = 0;
          if (pe) begin
            m_newc.delete();
            m_newc.push_back(kval);
            m_mode = M_PROG;
          end
        end else begin
          m_idle++;
          if (m_idle >= UNLOCK_CYC) m_mode = M_IDLE;
        end
      end
      M_PROG: begin
        if (rl) begin
          m_mode = M_IDLE;
          m_newc.delete();
        end else if (!pe) begin
          m_mode = M_UNL;
          m_idle = 0;
          m_newc.delete();
        end else if (kv) begin
          m_newc.push_back(kval);
          if (m_newc.size() == CODE_LEN) begin
            foreach (m_newc[i]) m_code[i] = m_newc[i];
            m_newc.delete();
            m_done = 1;
            m_mode = M_UNL;
            m_idle = 0;
          end
        end
      end
      default: begin
        m_lock_left--;
        if (m_lock_left == 0) begin
          m_mode = M_IDLE;
          m_fails = 0;
        end
      end
    endcase
  endtask

  function automatic logic [5:0] model_out();
    logic u;
    logic l;
    u = (m_mode == M_UNL) || (m_mode == M_PROG);
    l = (m_mode == M_LOCK);
    return {u, l, m_fail, m_done, 2'(MAX_TRIES - m_fails)};
  endfunction

  task automatic applyStimulus(input bit kv, input int kval, input bit pe, input bit rl);
    key_valid = kv;
    key_val   = 3'(kval);
    prog_en   = pe;
    relock    = rl;
    @(posedge clk);
    model_step(kv, kval, pe, rl);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = {unlock, lockout, fail_pulse, prog_done, tries_left};
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got unlock/lockout/fail/done/tries=%b/%b/%b/%b/%0d, expected %b/%b/%b/%b/%0d",
               name, act[5], act[4], act[3], act[2], act[1:0],
               exp[5], exp[4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  task automatic step(input string name, input bit kv, input int kval, input bit pe, input bit rl);
    applyStimulus(kv, kval, pe, rl);
    checkOutput(name, model_out());
  endtask

  task automatic idle(input string name, input int n, input bit pe);
    for (int i = 0; i < n; i++) step(name, 1'b0, 0, pe, 1'b0);
  endtask

  task automatic enter4(input string name, input int d0, input int d1, input int d2,
                        input int d3, input bit pe);
    step(name, 1'b1, d0, pe, 1'b0);
    step(name, 1'b1, d1, pe, 1'b0);
    step(name, 1'b1, d2, pe, 1'b0);
    step(name, 1'b1, d3, pe, 1'b0);
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    #2;
    model_reset();
    checkOutput(name, model_out());
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput(name, model_out());
  endtask

  typedef struct {
    bit kv;
    int kval;
    bit pe;
    bit rl;
    bit e_unlock;
    bit e_lockout;
    bit e_fail;
    bit e_done;
    int e_tries;
  } vec_t;

  vec_t vt[$];
  int   cnt;

  initial begin
    rst = 1'b1;
    key_valid = 1'b0;
    key_val = '0;
    prog_en = 1'b0;
    relock = 1'b0;
    model_reset();

    vt.push_back('{1, 1, 0, 0, 0, 0, 0, 0, 3});
    vt.push_back('{1, 1, 0, 0, 0, 0, 0, 0, 3});
    vt.push_back('{1, 2, 0, 0, 0, 0, 0, 0, 3});
    vt.push_back('{1, 3, 0, 0, 1, 0, 0, 0, 3});
    vt.push_back('{0, 0, 0, 0, 1, 0, 0, 0, 3});
    vt.push_back('{0, 0, 0, 1, 0, 0, 0, 0, 3});
    vt.push_back('{1, 1, 0, 0, 0, 0, 0, 0, 3});
    vt.push_back('{1, 1, 0, 0, 0, 0, 0, 0, 3});
    vt.push_back('{1, 2, 0, 0, 0, 0, 0, 0, 3});
    vt.push_back('{1, 4, 0, 0, 0, 0, 1, 0, 2});
    vt.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 2});
    vt.push_back('{1, 1, 0, 0, 0, 0, 0, 0, 2});
    vt.push_back('{1, 1, 0, 0, 0, 0, 0, 0, 2});
    vt.push_back('{1, 2, 0, 0, 0, 0, 0, 0, 2});
    vt.push_back('{1, 3, 0, 0, 1, 0, 0, 0, 3});
    vt.push_back('{1, 5, 1, 1, 0, 0, 0, 0, 3});
    vt.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 3});

    #12;
    checkOutput("reset_state", 6'b0000_11);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      applyStimulus(vt[i].kv, vt[i].kval, vt[i].pe, vt[i].rl);
      checkOutput($sformatf("table_%0d", i),
                  {vt[i].e_unlock, vt[i].e_lockout, vt[i].e_fail, vt[i].e_done, 2'(vt[i].e_tries)});
    end

    // Auto-relock: unlock must stay high for exactly UNLOCK_CYC samples.
    cnt = 0;
    enter4("unlock_open", 1, 1, 2, 3, 1'b0);
    if (unlock) cnt++;
    for (int i = 0; i < UNLOCK_CYC + 2; i++) begin
      step("unlock_idle", 1'b0, 0, 1'b0, 1'b0);
      if (unlock) cnt++;
    end
    vec_cnt++;
    if (cnt != UNLOCK_CYC) begin
      err_cnt++;
      $display("[TB] FAIL unlock_len: got %0d cycles, expected %0d", cnt, UNLOCK_CYC);
    end

    // Three bad entries then lockout with keys hammered throughout.
    enter4("bad1", 1, 1, 2, 4, 1'b0);
    enter4("bad2", 0, 1, 2, 3, 1'b0);
    cnt = 0;
    enter4("bad3", 7, 7, 7, 7, 1'b0);
    if (lockout) cnt++;
    for (int i = 0; i < LOCKOUT_CYC + 3; i++) begin
      step("lockout_keys", 1'b1, (i % 4 == 3) ? 3 : ((i % 4 == 2) ? 2 : 1), 1'b0, (i % 5) == 0);
      if (lockout) cnt++;
    end
    vec_cnt++;
    if (cnt != LOCKOUT_CYC) begin
      err_cnt++;
      $display("[TB] FAIL lockout_len: got %0d cycles, expected %0d", cnt, LOCKOUT_CYC);
    end
    idle("post_lock", 25, 1'b0);

    // Partial entry times out silently, then the correct code still works.
    step("partial", 1'b1, 1, 1'b0, 1'b0);
    step("partial", 1'b1, 1, 1'b0, 1'b0);
    idle("entry_to", ENTRY_TO, 1'b0);
    enter4("after_to", 1, 1, 2, 3, 1'b0);
    step("after_to_relock", 1'b0, 0, 1'b0, 1'b1);

    // Program a new code, confirm the old one fails and the new one opens.
    enter4("prog_open", 1, 1, 2, 3, 1'b0);
    enter4("prog_keys", 5, 6, 7, 0, 1'b1);
    step("prog_relock", 1'b0, 0, 1'b0, 1'b1);
    enter4("old_code", 1, 1, 2, 3, 1'b0);
    enter4("new_code", 5, 6, 7, 0, 1'b0);

    // Aborted programming leaves the code alone; relock beats a key.
    step("abort_p1", 1'b1, 2, 1'b1, 1'b0);
    step("abort_p2", 1'b1, 2, 1'b1, 1'b0);
    step("abort_fall", 1'b0, 0, 1'b0, 1'b0);
    step("abort_relock", 1'b1, 4, 1'b0, 1'b1);
    enter4("abort_old", 5, 6, 7, 0, 1'b0);
    step("prog_mid_relock_a", 1'b1, 1, 1'b1, 1'b0);
    step("prog_mid_relock_b", 1'b1, 2, 1'b1, 1'b1);
    step("prog_mid_relock_c", 1'b0, 0, 1'b0, 1'b0);

    step("rst_mid", 1'b1, 5, 1'b0, 1'b0);
    step("rst_mid", 1'b1, 6, 1'b0, 1'b0);
    do_reset("rst_mid_entry");
    enter4("default_back", 1, 1, 2, 3, 1'b0);
    step("default_relock", 1'b0, 0, 1'b0, 1'b1);

    // Random traffic, biased towards correct digits so unlock/program occur.
    begin
      bit pe_r;
      pe_r = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        bit kv;
        bit rl;
        int kval;
        int pos;
        kv = ($urandom % 3) == 0;
        rl = ($urandom % 60) == 0;
        if (($urandom % 24) == 0) pe_r = ~pe_r;
        pos = (m_mode == M_ENTRY) ? m_entry.size() : 0;
        if (pos >= CODE_LEN) pos = 0;
        kval = (($urandom % 4) != 0) ? m_code[pos] : int'($urandom % 8);
        step("random", kv, kval, pe_r, rl);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
